// File: rtl/max7219_ctrl.sv
// MAX7219/7221 command sequencer: fixed init sequence, then streams changed rows and brightness words.
// Latency: a pending word is loaded one cycle after o_spi_wr is low; acceptance is one edge at the earliest.
// Backpressure: each word is held on o_spi_data/o_spi_wr until a cycle with i_spi_busy low.
module max7219_ctrl #(
    parameter logic [3:0] INTENSITY  = 4'h8,
    parameter logic [2:0] SCAN_LIMIT = 3'd7
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fb_we,
    input  logic [2:0]  i_fb_row,
    input  logic [7:0]  i_fb_data,
    input  logic        i_int_we,
    input  logic [3:0]  i_int,
    output logic [15:0] o_spi_data,
    output logic        o_spi_wr,
    input  logic        i_spi_busy,
    output logic        o_init_done,
    output logic        o_idle
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_SCHED = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  init_idx_q;
    logic [15:0] spi_data_q;
    logic        spi_wr_q;
    logic        init_done_q;

    logic [7:0]  fb_q [8];
    logic [7:0]  dirty_q, dirty_d;
    logic [3:0]  int_q, int_d;
    logic        int_pend_q, int_pend_d;

    logic        accept;
    logic        load_int;
    logic        load_row;
    logic [2:0]  dirty_row;
    logic [15:0] init_word;
    logic [7:0]  row_addr;

    assign accept   = spi_wr_q & ~i_spi_busy;
    assign row_addr = {5'b0, dirty_row} + 8'd1;

    // Init word table; the intensity word uses the live brightness register.
    always_comb begin
        init_word = 16'h0C01;
        case (init_idx_q)
            3'd0:    init_word = 16'h0C01;
            3'd1:    init_word = {8'h0B, 5'b0, SCAN_LIMIT};
            3'd2:    init_word = 16'h0900;
            3'd3:    init_word = {8'h0A, 4'b0, int_q};
            3'd4:    init_word = 16'h0F00;
            default: init_word = 16'h0F00;
        endcase
    end

    // Lowest-index dirty row (only meaningful when some dirty bit is set).
    always_comb begin
        dirty_row = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (dirty_q[i]) begin
                dirty_row = 3'(i);
            end
        end
    end

    // Scheduler decision plus dirty/pending next state; a same-edge write beats the clear.
    always_comb begin
        load_int = 1'b0;
        load_row = 1'b0;
        if (state_q == ST_SCHED && !spi_wr_q) begin
            if (int_pend_q) begin
                load_int = 1'b1;
            end else if (|dirty_q) begin
                load_row = 1'b1;
            end
        end

        dirty_d = dirty_q;
        if (load_row) begin
            dirty_d[dirty_row] = 1'b0;
        end
        if (i_fb_we) begin
            dirty_d[i_fb_row] = 1'b1;
        end

        int_pend_d = int_pend_q;
        if (load_int) begin
            int_pend_d = 1'b0;
        end
        if (i_int_we) begin
            int_pend_d = 1'b1;
        end

        int_d = i_int_we ? i_int : int_q;
    end

    // Framebuffer, dirty bits and brightness register; writes are taken in every state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 8; i++) begin
                fb_q[i] <= 8'h00;
            end
            dirty_q    <= 8'hFF;
            int_q      <= INTENSITY;
            int_pend_q <= 1'b0;
        end else begin
            if (i_fb_we) begin
                fb_q[i_fb_row] <= i_fb_data;
            end
            dirty_q    <= dirty_d;
            int_q      <= int_d;
            int_pend_q <= int_pend_d;
        end
    end

    // Command FSM: owns the registered word, write request and init-done flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_INIT;
            init_idx_q  <= 3'd0;
            spi_data_q  <= 16'h0000;
            spi_wr_q    <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (!spi_wr_q) begin
                        spi_data_q <= init_word;
                        spi_wr_q   <= 1'b1;
                    end else if (accept) begin
                        spi_wr_q <= 1'b0;
                        if (init_idx_q == 3'd4) begin
                            init_done_q <= 1'b1;
                            state_q     <= ST_SCHED;
                        end else begin
                            init_idx_q <= init_idx_q + 3'd1;
                        end
                    end
                end
                ST_SCHED: begin
                    if (load_int) begin
                        spi_data_q <= {8'h0A, 4'b0, int_q};
                        spi_wr_q   <= 1'b1;
                        state_q    <= ST_SEND;
                    end else if (load_row) begin
                        spi_data_q <= {row_addr, fb_q[dirty_row]};
                        spi_wr_q   <= 1'b1;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        spi_wr_q <= 1'b0;
                        state_q  <= ST_SCHED;
                    end
                end
                default: begin
                    state_q  <= ST_INIT;
                    spi_wr_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_spi_data  = spi_data_q;
    assign o_spi_wr    = spi_wr_q;
    assign o_init_done = init_done_q;
    assign o_idle      = init_done_q & ~spi_wr_q & ~int_pend_q & ~(|dirty_q);

endmodule

// File: tb/tb_max7219_ctrl.sv
// Bench for max7219_ctrl: transmitter model, expected-word queue and device register image.
// Latency: every accepted word is checked against the queue; protocol and flags are checked every cycle.
// Backpressure: transmitter is busy 20 cycles after each acceptance, plus forced busy windows.
module tb_max7219_ctrl;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_fb_we = 1'b0;
    logic [2:0]  i_fb_row = 3'd0;
    logic [7:0]  i_fb_data = 8'h00;
    logic        i_int_we = 1'b0;
    logic [3:0]  i_int = 4'h0;
    logic [15:0] o_spi_data;
    logic        o_spi_wr;
    logic        i_spi_busy = 1'b1;
    logic        o_init_done;
    logic        o_idle;

    max7219_ctrl #(.INTENSITY(4'h8), .SCAN_LIMIT(3'd7)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_fb_we     (i_fb_we),
        .i_fb_row    (i_fb_row),
        .i_fb_data   (i_fb_data),
        .i_int_we    (i_int_we),
        .i_int       (i_int),
        .o_spi_data  (o_spi_data),
        .o_spi_wr    (o_spi_wr),
        .i_spi_busy  (i_spi_busy),
        .o_init_done (o_init_done),
        .o_idle      (o_idle)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state
    logic [15:0] exp_q[$];
    logic [15:0] exp_stage[$];
    logic [7:0]  dev [256];
    logic [7:0]  fb_sh [8];
    logic [3:0]  int_sh = 4'h8;
    logic        model_done = 1'b0;
    int          acc_since_rst = 0;
    int          acc_total = 0;
    logic        force_busy = 1'b1;
    int          busy_cnt = 0;

    // Monitor history (state seen one cycle earlier)
    logic        prev_rst = 1'b1;
    logic        prev_wr = 1'b0;
    logic        prev_acc = 1'b0;
    logic [15:0] prev_data = 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dev[i] = 8'h00;
        for (int i = 0; i < 8; i++) fb_sh[i] = 8'h00;
    end

    // Monitor + transmitter model: runs just after each falling edge, after stimulus settles.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (prev_rst) begin
                chk("rst_wr", {31'b0, o_spi_wr}, 32'd0);
                chk("rst_data", {16'b0, o_spi_data}, 32'd0);
                chk("rst_done", {31'b0, o_init_done}, 32'd0);
                chk("rst_idle", {31'b0, o_idle}, 32'd0);
                exp_q.delete();
                exp_stage.delete();
                exp_q.push_back(16'h0C01);
                exp_q.push_back(16'h0B07);
                exp_q.push_back(16'h0900);
                exp_q.push_back(16'h0A08);
                exp_q.push_back(16'h0F00);
                for (int r = 1; r <= 8; r++) exp_q.push_back({8'(r), 8'h00});
                for (int r = 0; r < 8; r++) fb_sh[r] = 8'h00;
                int_sh = 4'h8;
                model_done = 1'b0;
                acc_since_rst = 0;
                busy_cnt = 0;
            end else begin
                if (prev_acc) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", {16'b0, prev_data}, 32'hFFFFFFFF);
                    end else begin
                        chk("word", {16'b0, prev_data}, {16'b0, exp_q.pop_front()});
                    end
                    dev[prev_data[15:8]] = prev_data[7:0];
                    acc_total++;
                    acc_since_rst++;
                    if (acc_since_rst == 5) model_done = 1'b1;
                    chk("wr_drop", {31'b0, o_spi_wr}, 32'd0);
                    busy_cnt = 20;
                end else if (prev_wr) begin
                    chk("hold_wr", {31'b0, o_spi_wr}, 32'd1);
                    chk("hold_data", {16'b0, o_spi_data}, {16'b0, prev_data});
                end
                chk("init_done", {31'b0, o_init_done}, {31'b0, model_done});
                chk("idle", {31'b0, o_idle},
                    {31'b0, model_done && !o_spi_wr && exp_q.size() == 0});
            end
            while (exp_stage.size() > 0) exp_q.push_back(exp_stage.pop_front());
            i_spi_busy = force_busy || (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            prev_acc  = o_spi_wr && !i_spi_busy && !i_rst;
            prev_wr   = o_spi_wr;
            prev_data = o_spi_data;
            prev_rst  = i_rst;
        end
    end

    task automatic write_row(input logic [2:0] r, input logic [7:0] d);
        i_fb_we = 1'b1;
        i_fb_row = r;
        i_fb_data = d;
        fb_sh[r] = d;
        @(negedge clk);
        i_fb_we = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (!o_idle && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!o_idle) chk({name, "_timeout"}, 32'd0, 32'd1);
        #2;
        chk({name, "_drained"}, exp_q.size(), 32'd0);
        for (int r = 0; r < 8; r++) chk({name, "_dev_row"}, {24'b0, dev[r + 1]}, {24'b0, fb_sh[r]});
        chk({name, "_dev_int"}, {24'b0, dev[8'h0A]}, {28'b0, int_sh});
    endtask

    task automatic wait_word(input string name, input logic [15:0] w, input int limit);
        int n = 0;
        while (!(o_spi_wr && o_spi_data == w) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!(o_spi_wr && o_spi_data == w)) chk({name, "_timeout"}, {16'b0, o_spi_data}, {16'b0, w});
    endtask

    initial begin
        // Reset with the transmitter busy for 10 cycles afterwards.
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        repeat (10) @(negedge clk);
        force_busy = 1'b0;
        wait_idle("init", 3000);
        chk("init_count", acc_total, 32'd13);
        chk("dev_shutdown", {24'b0, dev[8'h0C]}, 32'h01);
        chk("dev_scan", {24'b0, dev[8'h0B]}, 32'h07);
        chk("dev_decode", {24'b0, dev[8'h09]}, 32'h00);
        chk("dev_int_reset", {24'b0, dev[8'h0A]}, 32'h08);
        chk("dev_test", {24'b0, dev[8'h0F]}, 32'h00);

        // Word held for 50 busy cycles; rows 5 then 2 written meanwhile go out lowest row first.
        @(negedge clk);
        force_busy = 1'b1;
        exp_stage.push_back(16'h0855);
        write_row(3'd7, 8'h55);
        wait_word("hold", 16'h0855, 20);
        exp_stage.push_back(16'h033C);
        exp_stage.push_back(16'h06A5);
        write_row(3'd5, 8'hA5);
        write_row(3'd2, 8'h3C);
        repeat (48) @(negedge clk);
        force_busy = 1'b0;
        wait_idle("prio", 2000);
        chk("prio_count", acc_total, 32'd16);
        chk("dev_row7", {24'b0, dev[8'h08]}, 32'h55);

        // Brightness and row 0 in the same cycle: brightness first.
        @(negedge clk);
        exp_stage.push_back(16'h0A0F);
        exp_stage.push_back(16'h0181);
        i_int_we = 1'b1;
        i_int = 4'hF;
        int_sh = 4'hF;
        write_row(3'd0, 8'h81);
        i_int_we = 1'b0;
        wait_idle("int", 2000);
        chk("dev_int_f", {24'b0, dev[8'h0A]}, 32'h0F);

        // Rewrite of a row whose word is outstanding.
        @(negedge clk);
        force_busy = 1'b1;
        exp_stage.push_back(16'h0411);
        write_row(3'd3, 8'h11);
        wait_word("out", 16'h0411, 20);
        exp_stage.push_back(16'h0422);
        write_row(3'd3, 8'h22);
        repeat (3) @(negedge clk);
        force_busy = 1'b0;
        wait_idle("rewrite", 2000);
        chk("dev_row3", {24'b0, dev[8'h04]}, 32'h22);

        // Reset during the post-init refresh, once 0300 has been loaded.
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        wait_word("refresh", 16'h0300, 2000);
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        wait_idle("rerst", 3000);
        chk("dev_int_back", {24'b0, dev[8'h0A]}, 32'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got running, required finished");
        $fatal(1);
    end

endmodule

// File: doc/max7219_ctrl.md
Name: max7219_ctrl

Overview:
- Command sequencer that sits between the user logic and the SPI transmitter serving a single MAX7219/7221 8x8 LED driver.
- After reset it issues the fixed device initialisation sequence.
- It then holds an 8-row framebuffer and a brightness register, and streams only changed rows (and brightness updates) to the transmitter as 16-bit {address, data} words.
- It obeys the transmitter's write/busy handshake, so user logic never touches SPI timing.

Parameters:
- INTENSITY, 4'h8: brightness value loaded into the intensity register at reset; sent during init.
- SCAN_LIMIT, 3'd7: scan-limit value sent during init (7 = all 8 digits).

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  reset, synchronous, active-high
- i_fb_we  input  1  framebuffer write strobe, one row per cycle
- i_fb_row  input  3  row index 0..7 (device digit register = row+1)
- i_fb_data  input  8  row pixel bits
- i_int_we  input  1  brightness update strobe
- i_int  input  4  new brightness value
- o_spi_data  output  16  command word to transmitter, {addr[7:0], data[7:0]}
- o_spi_wr  output  1  write request to transmitter
- i_spi_busy  input  1  transmitter busy; a request is accepted only on a cycle with o_spi_wr=1 and i_spi_busy=0
- o_init_done  output  1  high once all init words are accepted
- o_idle  output  1  init done, nothing pending, no request outstanding

Behaviour:
- Reset (synchronous, i_rst=1):
  - Outputs: o_spi_wr=0, o_spi_data=16'h0000, o_init_done=0, o_idle=0, state=INIT with init index 0.
  - Internal: framebuffer all 8'h00, all 8 row dirty bits =1, intensity register=INTENSITY, intensity pending=0.
  - Reset mid-transfer simply drops o_spi_wr; the transmitter is reset by the same i_rst.
- Handshake:
  - When a word is loaded, o_spi_data is set and o_spi_wr=1 on the same edge.
  - Both are held stable until the acceptance edge (o_spi_wr & !i_spi_busy sampled at posedge).
  - On the acceptance edge o_spi_wr goes 0, so it is low the following cycle.
  - At most one word is loaded per two cycles.
  - The controller never waits for transfer completion: the transmitter's busy blocks the next acceptance.
- States:
  - INIT:
    - Loads words in order: 16'h0C01 (shutdown off), {8'h0B,5'b0,SCAN_LIMIT}, 16'h0900 (no decode), {8'h0A,4'b0,intensity}, 16'h0F00 (test off).
    - Each word is loaded once the previous one is accepted.
    - After the fifth word is accepted: o_init_done=1, go to SCHED.
    - Transmitter busy after reset only delays acceptance.
  - SCHED, evaluated only when o_spi_wr=0, with priority:
    - (1) intensity pending: load {8'h0A,4'b0,intensity}, clear pending, go to SEND.
    - (2) lowest-index dirty row r: load {5'b0,r+1, fb[r]}, clear dirty[r], go to SEND.
    - (3) otherwise stay; o_idle=1.
  - SEND: hold the word until acceptance, then return to SCHED.
- Framebuffer writes:
  - Accepted in every state, including INIT.
  - A write stores data and sets dirty[row].
  - If the write hits the row being loaded on the same edge, set wins over clear (row re-sent later).
  - A write to a row already latched into o_spi_data does not alter the outstanding word; it marks the row dirty again.
- Brightness writes: i_int_we stores i_int and sets pending.
  - During INIT before the intensity word is loaded, the new value is sent in INIT; pending is still set, so it is resent once (harmless).
  - Simultaneous set and clear: set wins.
- o_idle is combinational:
  - o_init_done & !o_spi_wr & !pending & dirty==0.
  - Low during reset and INIT.

Test Plan:
- Reset with i_spi_busy=1 for 10 cycles, then 0, transmitter model accepting every word and busy 20 cycles each:
  - Exactly 0C01, 0B07, 0900, 0A08, 0F00, then 0100..0800.
  - o_init_done rises after the 0F00 acceptance; o_idle=1 after the 0800 acceptance.
- Busy held high 50 cycles while o_spi_wr=1 -> o_spi_data and o_spi_wr remain constant every cycle; exactly one acceptance occurs.
- Idle, then write row 5=8'hA5 and row 2=8'h3C in consecutive cycles -> words 033C then 06A5, nothing else.
- Idle, write i_int=4'hF and row 0=8'h81 same cycle -> 0A0F sent before 0181.
- Write row 3=8'h11, then row 3=8'h22 while 0411 is outstanding -> 0411 accepted unchanged, followed by 0422.
- Assert i_rst mid-refresh (after 0300 loaded) -> next cycle o_spi_wr=0, o_init_done=0; the full init sequence restarts from 0C01.
